// File: rtl/q_row_fetch.sv
// Q-row fetch: reads ACTIONS consecutive Q-values of one state from the Q-table RAM
// and presents them as a single packed row with a one-cycle valid pulse.
module q_row_fetch #(
  parameter int DATA_WIDTH    = 32,
  parameter int ACTIONS       = 4,
  parameter int ACTIONS_WIDTH = 2,
  parameter int STATE_WIDTH   = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_valid,
  input  logic [STATE_WIDTH-1:0]              i_state,
  output logic                                o_ready,
  output logic                                o_rd_en,
  output logic [STATE_WIDTH+ACTIONS_WIDTH-1:0] o_rd_addr,
  input  logic [DATA_WIDTH-1:0]               i_rd_data,
  output logic [DATA_WIDTH*ACTIONS-1:0]       o_data,
  output logic [STATE_WIDTH-1:0]              o_state,
  output logic                                o_valid
);

  localparam logic [ACTIONS_WIDTH-1:0] LAST_ACTION = ACTIONS_WIDTH'(ACTIONS - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} fsm_t;

  fsm_t                                  r_fsm, w_fsm_next;
  logic [STATE_WIDTH-1:0]                r_req_state, w_req_state_next;
  logic [ACTIONS_WIDTH-1:0]              r_rd_cnt, w_rd_cnt_next;
  logic                                  r_cap_en;
  logic [ACTIONS_WIDTH-1:0]              r_cap_idx;
  logic                                  r_ready, w_ready_next;
  logic                                  r_rd_en, w_rd_en_next;
  logic [STATE_WIDTH+ACTIONS_WIDTH-1:0]  r_rd_addr, w_rd_addr_next;
  logic [DATA_WIDTH*ACTIONS-1:0]         r_data, w_data_next;
  logic [STATE_WIDTH-1:0]                r_state_out, w_state_out_next;
  logic                                  r_valid, w_valid_next;
  logic [DATA_WIDTH*ACTIONS-1:0]         w_row;
  logic                                  w_last_cap;

  // Row buffer: the word returning this cycle is merged into w_row so the
  // complete row can be copied to o_data on the same edge that captures it.
  genvar gi;
  generate
    for (gi = 0; gi < ACTIONS; gi++) begin : g_slot
      logic [DATA_WIDTH-1:0] r_slot;
      logic                  w_hit;
      assign w_hit = r_cap_en && (r_cap_idx == ACTIONS_WIDTH'(gi));
      always_ff @(posedge clk) begin
        if (rst) begin
          r_slot <= '0;
        end else if (w_hit) begin
          r_slot <= i_rd_data;
        end
      end
      assign w_row[DATA_WIDTH*(ACTIONS-gi)-1 -: DATA_WIDTH] = w_hit ? i_rd_data : r_slot;
    end
  endgenerate

  assign w_last_cap = r_cap_en && (r_cap_idx == LAST_ACTION);

  always_comb begin
    w_fsm_next       = r_fsm;
    w_req_state_next = r_req_state;
    w_rd_cnt_next    = r_rd_cnt;
    w_ready_next     = 1'b0;
    w_rd_en_next     = 1'b0;
    w_rd_addr_next   = r_rd_addr;
    w_data_next      = r_data;
    w_state_out_next = r_state_out;
    w_valid_next     = 1'b0;
    case (r_fsm)
      IDLE, DONE: begin
        if (i_valid) begin
          w_fsm_next       = READ;
          w_req_state_next = i_state;
          w_rd_cnt_next    = '0;
          w_rd_en_next     = 1'b1;
          w_rd_addr_next   = {i_state, {ACTIONS_WIDTH{1'b0}}};
        end else begin
          w_fsm_next   = IDLE;
          w_ready_next = 1'b1;
        end
      end
      READ: begin
        if (r_rd_cnt == LAST_ACTION) begin
          w_fsm_next = DRAIN;
        end else begin
          w_rd_cnt_next  = r_rd_cnt + 1'b1;
          w_rd_en_next   = 1'b1;
          w_rd_addr_next = {r_req_state, r_rd_cnt + 1'b1};
        end
      end
      DRAIN: begin
        if (w_last_cap) begin
          w_fsm_next       = DONE;
          w_ready_next     = 1'b1;
          w_valid_next     = 1'b1;
          w_data_next      = w_row;
          w_state_out_next = r_req_state;
        end
      end
      default: w_fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= IDLE;
      r_req_state <= '0;
      r_rd_cnt    <= '0;
      r_cap_en    <= 1'b0;
      r_cap_idx   <= '0;
      r_ready     <= 1'b1;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_data      <= '0;
      r_state_out <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_fsm       <= w_fsm_next;
      r_req_state <= w_req_state_next;
      r_rd_cnt    <= w_rd_cnt_next;
      r_cap_en    <= r_rd_en;
      r_cap_idx   <= r_rd_cnt;
      r_ready     <= w_ready_next;
      r_rd_en     <= w_rd_en_next;
      r_rd_addr   <= w_rd_addr_next;
      r_data      <= w_data_next;
      r_state_out <= w_state_out_next;
      r_valid     <= w_valid_next;
    end
  end

  assign o_ready   = r_ready;
  assign o_rd_en   = r_rd_en;
  assign o_rd_addr = r_rd_addr;
  assign o_data    = r_data;
  assign o_state   = r_state_out;
  assign o_valid   = r_valid;

endmodule

// File: tb/tb_q_row_fetch.sv
// Scoreboard bench for q_row_fetch: stimulus pushes expected reads and rows,
// a negedge monitor pops and compares whenever the DUT reads or pulses o_valid.
module tb_q_row_fetch;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_valid = 1'b0;
  logic [7:0]   i_state = 8'd0;
  logic         o_ready, o_rd_en, o_valid;
  logic [9:0]   o_rd_addr;
  logic [31:0]  i_rd_data;
  logic [127:0] o_data;
  logic [7:0]   o_state;

  localparam logic [127:0] ROW3   = 128'hC156000041A10A3D41A10A3D40B89374;
  localparam logic [127:0] ROW255 = 128'h00000001000000020000000300000004;
  localparam logic [127:0] ROW2A  = 128'h11111111222222223333333344444444;

  always #5 clk = ~clk;

  q_row_fetch #(.DATA_WIDTH(32), .ACTIONS(4), .ACTIONS_WIDTH(2), .STATE_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_state(i_state), .o_ready(o_ready),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .o_data(o_data), .o_state(o_state), .o_valid(o_valid)
  );

  logic [31:0] ram [0:1023];
  always @(posedge clk) if (o_rd_en) i_rd_data <= ram[o_rd_addr];

  int   cyc = 0;
  logic rst_seen = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  typedef struct {logic [9:0] addr; int cyc;} addr_t;
  typedef struct {logic [127:0] data; logic [7:0] st; int cyc;} row_t;
  addr_t addr_q[$];
  row_t  row_q[$];

  int           checks = 0;
  int           failures = 0;
  logic [127:0] hold_data = '0;
  logic [127:0] last_row = '0;
  logic         prev_valid = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    addr_t a;
    row_t  r;
    if (rst_seen) begin
      addr_q.delete();
      row_q.delete();
      hold_data = '0;
      chk("reset_rd_en", 128'(o_rd_en), 128'd0);
      chk("reset_ready", 128'(o_ready), 128'd1);
      chk("reset_valid", 128'(o_valid), 128'd0);
      chk("reset_data", o_data, 128'd0);
      chk("reset_state", 128'(o_state), 128'd0);
      chk("reset_rd_addr", 128'(o_rd_addr), 128'd0);
    end else begin
      if (o_rd_en) begin
        if (addr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_read: rd_addr=%h at cycle %0d, expected no read", o_rd_addr, cyc);
        end else begin
          a = addr_q.pop_front();
          chk("rd_addr", 128'(o_rd_addr), 128'(a.addr));
          chk("rd_cycle", 128'(cyc), 128'(a.cyc));
        end
      end
      if (o_valid) begin
        chk("valid_not_consecutive", 128'(prev_valid), 128'd0);
        chk("ready_in_done", 128'(o_ready), 128'd1);
        if (row_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_valid: o_data=%h o_state=%h at cycle %0d, expected none", o_data, o_state, cyc);
        end else begin
          r = row_q.pop_front();
          chk("row_data", o_data, r.data);
          chk("row_state", 128'(o_state), 128'(r.st));
          chk("row_cycle", 128'(cyc), 128'(r.cyc));
          hold_data = r.data;
        end
        last_row = o_data;
      end else begin
        chk("o_data_hold", o_data, hold_data);
      end
    end
    prev_valid = o_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_row(input logic [7:0] s, input logic [127:0] d, input int base);
    for (int a = 0; a < 4; a++) addr_q.push_back(addr_t'{{s, 2'(a)}, base + 1 + a});
    row_q.push_back(row_t'{d, s, base + 6});
  endtask

  task automatic request(input logic [7:0] s, input logic [127:0] d);
    i_valid = 1'b1;
    i_state = s;
    push_row(s, d, cyc);
    tick();
    i_valid = 1'b0;
    i_state = 8'd0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && (addr_q.size() != 0 || row_q.size() != 0); i++) tick();
    chk("drain_pending", 128'(addr_q.size() + row_q.size()), 128'd0);
    repeat (3) tick();
  endtask

  // Max over a packed row as the downstream max unit sees it: first index wins ties.
  function automatic int max_idx(input logic [127:0] row);
    logic [31:0] v, k, best_k;
    int best;
    best = 0;
    best_k = '0;
    for (int i = 0; i < 4; i++) begin
      v = row[127 - 32*i -: 32];
      k = v[31] ? ~v : (v | 32'h8000_0000);
      if (i == 0 || k > best_k) begin
        best_k = k;
        best = i;
      end
    end
    return best;
  endfunction

  initial begin
    int mi;
    for (int i = 0; i < 1024; i++) ram[i] = 32'hDEAD0000 | i;
    ram[10'h00C] = 32'hC1560000; ram[10'h00D] = 32'h41A10A3D;
    ram[10'h00E] = 32'h41A10A3D; ram[10'h00F] = 32'h40B89374;
    ram[10'h3FC] = 32'h00000001; ram[10'h3FD] = 32'h00000002;
    ram[10'h3FE] = 32'h00000003; ram[10'h3FF] = 32'h00000004;
    ram[10'h0A8] = 32'h11111111; ram[10'h0A9] = 32'h22222222;
    ram[10'h0AA] = 32'h33333333; ram[10'h0AB] = 32'h44444444;

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // single fetch of state 3 with a busy-time request for state 7 ignored
    request(8'd3, ROW3);
    tick();
    i_valid = 1'b1; i_state = 8'd7;
    repeat (3) tick();
    i_valid = 1'b0; i_state = 8'd0;
    wait_drain();
    mi = max_idx(last_row);
    chk("max_index", 128'(mi), 128'd1);
    chk("max_value", last_row[127 - 32*mi -: 32], 128'h41A10A3D);

    // back-to-back: state 3 then state 255 accepted in the DONE cycle
    i_valid = 1'b1; i_state = 8'd3;
    push_row(8'd3, ROW3, cyc);
    push_row(8'd255, ROW255, cyc + 6);
    tick();
    i_state = 8'd255;
    repeat (6) tick();
    i_valid = 1'b0; i_state = 8'd0;
    wait_drain();

    // reset in cycle 3 of a fetch discards the row; a new fetch then works
    request(8'd3, ROW3);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (8) tick();
    request(8'h2A, ROW2A);
    wait_drain();

    // reset and request in the same cycle: request dropped
    rst = 1'b1; i_valid = 1'b1; i_state = 8'd5;
    tick();
    rst = 1'b0; i_valid = 1'b0; i_state = 8'd0;
    repeat (10) tick();
    chk("final_pending", 128'(addr_q.size() + row_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
